// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - LC-3b MEM-stage multi-cycle memory access sequencer (optional MEMSEQ_WATCHDOG_EN)
module mem_access_sequencer #(
    parameter int WIDTH   = 16,
    parameter int LANES   = WIDTH / 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             err_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic [WIDTH-1:0] mem_address_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    output logic [LANES-1:0] mem_byte_enable_o,
    input  logic             mem_resp_i,
    input  logic [WIDTH-1:0] mem_rdata_i
);

    localparam int LSB = $clog2(LANES);

    localparam logic [2:0] OP_LDW  = 3'd0;
    localparam logic [2:0] OP_STW  = 3'd1;
    localparam logic [2:0] OP_LDB  = 3'd2;
    localparam logic [2:0] OP_STB  = 3'd3;
    localparam logic [2:0] OP_LDI  = 3'd4;
    localparam logic [2:0] OP_STI  = 3'd5;
    localparam logic [2:0] OP_TRAP = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [LSB-1:0]     lane_q, lane_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [LANES-1:0]   be_q, be_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;

    logic               in_acc;
    logic               timeout_hit;
    logic [7:0]         load_byte;

    assign in_acc = (state_q == S_ACC1) || (state_q == S_ACC2);

`ifdef MEMSEQ_WATCHDOG_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [WD_W-1:0] wd_q, wd_d;

    // Abort on the edge where the counter would reach TIMEOUT without a response
    assign timeout_hit = in_acc && !mem_resp_i && (wd_q == WD_W'(TIMEOUT - 1));

    // Watchdog counter: cleared when entering an access state, counts unanswered cycles
    always_comb begin
        wd_d = wd_q;
        if ((state_d == S_ACC1 || state_d == S_ACC2) && (state_d != state_q)) begin
            wd_d = '0;
        end else if (in_acc && !mem_resp_i) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    // Byte lane picked by the low address bits of a byte load
    assign load_byte = mem_rdata_i[int'(lane_q) * 8 +: 8];

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one or two handshaked accesses, then a single DONE cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (op_i == OP_NOP) ? S_DONE : S_ACC1;
                end
            end
            S_ACC1: begin
                if (timeout_hit) begin
                    state_d = S_IDLE;
                end else if (mem_resp_i) begin
                    state_d = (op_q == OP_LDI || op_q == OP_STI) ? S_ACC2 : S_DONE;
                end
            end
            S_ACC2: begin
                if (timeout_hit) begin
                    state_d = S_IDLE;
                end else if (mem_resp_i) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered memory-port and result outputs
    always_comb begin
        op_d          = op_q;
        lane_d        = lane_q;
        wdata_d       = wdata_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        be_d          = be_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        rdata_d       = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d          = op_i;
                    lane_d        = addr_i[LSB-1:0];
                    wdata_d       = wdata_i;
                    mem_address_d = {addr_i[WIDTH-1:LSB], {LSB{1'b0}}};
                    mem_wdata_d   = wdata_i;
                    be_d          = '0;
                    mem_read_d    = 1'b0;
                    mem_write_d   = 1'b0;
                    case (op_i)
                        OP_LDW, OP_LDB, OP_LDI, OP_STI, OP_TRAP: mem_read_d = 1'b1;
                        OP_STW: begin
                            mem_write_d = 1'b1;
                            be_d        = '1;
                        end
                        OP_STB: begin
                            mem_write_d = 1'b1;
                            be_d        = LANES'(1) << addr_i[LSB-1:0];
                            mem_wdata_d = {LANES{wdata_i[7:0]}};
                        end
                        default: begin
                            done_d  = 1'b1;
                            rdata_d = '0;
                        end
                    endcase
                end
            end
            S_ACC1, S_ACC2: begin
                if (timeout_hit) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    be_d        = '0;
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                    rdata_d     = '0;
                end else if (mem_resp_i) begin
                    if (state_q == S_ACC1 && (op_q == OP_LDI || op_q == OP_STI)) begin
                        // Pointer fetched: second access goes to the aligned pointer target
                        mem_address_d = {mem_rdata_i[WIDTH-1:LSB], {LSB{1'b0}}};
                        if (op_q == OP_STI) begin
                            mem_read_d  = 1'b0;
                            mem_write_d = 1'b1;
                            mem_wdata_d = wdata_q;
                            be_d        = '1;
                        end
                    end else begin
                        mem_read_d  = 1'b0;
                        mem_write_d = 1'b0;
                        be_d        = '0;
                        done_d      = 1'b1;
                        case (op_q)
                            OP_LDW, OP_LDI, OP_TRAP: rdata_d = mem_rdata_i;
                            OP_LDB:  rdata_d = {{(WIDTH-8){load_byte[7]}}, load_byte};
                            default: rdata_d = '0;
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            op_q          <= OP_NOP;
            lane_q        <= '0;
            wdata_q       <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            be_q          <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
        end else begin
            op_q          <= op_d;
            lane_q        <= lane_d;
            wdata_q       <= wdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            be_q          <= be_d;
            done_q        <= done_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
        end
    end

    // Upstream is frozen while an op is requested or an access is in flight
    assign stall_o           = start_i | in_acc;
    assign done_o            = done_q;
    assign err_o             = err_q;
    assign rdata_o           = rdata_q;
    assign mem_read_o        = mem_read_q;
    assign mem_write_o       = mem_write_q;
    assign mem_address_o     = mem_address_q;
    assign mem_wdata_o       = mem_wdata_q;
    assign mem_byte_enable_o = be_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - scoreboard bench for mem_access_sequencer
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic        stall, done, err, mem_read, mem_write, mem_resp;
    logic [15:0] rdata, mem_address, mem_wdata, mem_rdata;
    logic [1:0]  mem_be;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [1:0]  be;
    } acc_t;

    logic [16:0] exp_q[$];
    acc_t        acc_q[$];

    logic [15:0] mem [0:65535];
    int          wait_n = 0;
    int          wcnt = 0;
    logic        resp_en = 1'b1;
    logic        force_resp = 1'b0;
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = 16'h0;
    logic [15:0] ld_data = 16'h0;

    int          stall_drops = 0;
    logic        c1_read;
    logic [15:0] c1_addr;
    int          lat;

    mem_access_sequencer #(.WIDTH(16), .LANES(2), .TIMEOUT(4)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op), .addr_i(addr),
        .wdata_i(wdata), .stall_o(stall), .done_o(done), .rdata_o(rdata), .err_o(err),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_address_o(mem_address),
        .mem_wdata_o(mem_wdata), .mem_byte_enable_o(mem_be), .mem_resp_i(mem_resp),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_resp  = force_resp || (resp_en && (mem_read || mem_write) && (wcnt == wait_n));
        mem_rdata = mem[mem_address];
    end

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (resp_en && (mem_read || mem_write)) wcnt <= mem_resp ? 0 : wcnt + 1;
        else wcnt <= 0;
        if (mem_resp && mem_write && !force_resp) begin
            if (mem_be[0]) mem[mem_address][7:0]  <= mem_wdata[7:0];
            if (mem_be[1]) mem[mem_address][15:8] <= mem_wdata[15:8];
        end
    end

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: completed ops against expected results
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) check("unexpected_done", {19'h0, err, rdata}, 36'h0_DEAD_BEEF);
            else check("done_result", {19'h0, err, rdata}, {19'h0, exp_q.pop_front()});
        end
    end

    // Monitor: each answered memory access against expected accesses
    always @(negedge clk) begin
        if (!reset && mem_resp && !force_resp) begin
            acc_t act;
            act.wr = mem_write;
            act.a  = mem_address;
            act.d  = mem_write ? mem_wdata : 16'h0;
            act.be = mem_write ? mem_be : 2'b00;
            if (acc_q.size() == 0) check("unexpected_access", {1'b0, act}, 36'hF_FFFF_FFFF);
            else check("mem_access", {1'b0, act}, {1'b0, acc_q.pop_front()});
        end
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        ld_addr = a; ld_data = d; ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic push_rd(input logic [15:0] a);
        acc_q.push_back('{wr: 1'b0, a: a, d: 16'h0, be: 2'b00});
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        acc_q.push_back('{wr: 1'b1, a: a, d: d, be: be});
    endtask

    task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] wd,
                          input logic e, input logic [15:0] exp_rd, output int l);
        exp_q.push_back({e, exp_rd});
        @(posedge clk); #1;
        start = 1'b1; op = o; addr = a; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0;
        l = 1;
        c1_read = mem_read;
        c1_addr = mem_address;
        while (!done && l < 100) begin
            if (!stall) stall_drops++;
            @(posedge clk); #1;
            l++;
        end
        if (!done) check("done_timeout", 36'(l), 36'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_strobes", {32'h0, mem_read, mem_write, done, err}, 36'h0);
        check("reset_rdata_addr", {4'h0, rdata, mem_address}, 36'h0);
        check("reset_wdata_be_stall", {17'h0, mem_wdata, mem_be, stall}, 36'h0);

        preload(16'h3000, 16'hBEEF);
        push_rd(16'h3000);
        run_op(3'd0, 16'h3001, 16'h0, 1'b0, 16'hBEEF, lat);
        check("ldw_latency", 36'(lat), 36'd2);
        check("ldw_cycle1", {19'h0, c1_read, c1_addr}, {19'h0, 1'b1, 16'h3000});

        preload(16'h3000, 16'h80AA);
        push_rd(16'h3000);
        run_op(3'd2, 16'h3001, 16'h0, 1'b0, 16'hFF80, lat);
        push_rd(16'h3000);
        run_op(3'd2, 16'h3000, 16'h0, 1'b0, 16'hFFAA, lat);
        preload(16'h3002, 16'h1234);
        push_rd(16'h3002);
        run_op(3'd2, 16'h3002, 16'h0, 1'b0, 16'h0034, lat);

        push_wr(16'h3000, 16'h3434, 2'b01);
        run_op(3'd3, 16'h3000, 16'h1234, 1'b0, 16'h0000, lat);
        push_wr(16'h3000, 16'hABAB, 2'b10);
        run_op(3'd3, 16'h3001, 16'h00AB, 1'b0, 16'h0000, lat);
        push_rd(16'h3000);
        run_op(3'd0, 16'h3000, 16'h0, 1'b0, 16'hAB34, lat);

        push_wr(16'h2002, 16'hCAFE, 2'b11);
        run_op(3'd1, 16'h2003, 16'hCAFE, 1'b0, 16'h0000, lat);
        push_rd(16'h2002);
        run_op(3'd0, 16'h2002, 16'h0, 1'b0, 16'hCAFE, lat);

        wait_n = 2;
        preload(16'h4000, 16'h5003);
        preload(16'h5002, 16'h00CD);
        stall_drops = 0;
        push_rd(16'h4000);
        push_rd(16'h5002);
        run_op(3'd4, 16'h4000, 16'h0, 1'b0, 16'h00CD, lat);
        check("ldi_latency", 36'(lat), 36'd7);
        check("ldi_stall_held", 36'(stall_drops), 36'd0);

        wait_n = 1;
        preload(16'h0046, 16'h1A00);
        push_rd(16'h0046);
        run_op(3'd6, 16'h0046, 16'h0, 1'b0, 16'h1A00, lat);
        check("trap_latency", 36'(lat), 36'd3);

        wait_n = 0;
        preload(16'h4100, 16'h6001);
        push_rd(16'h4100);
        push_wr(16'h6000, 16'h7777, 2'b11);
        run_op(3'd5, 16'h4100, 16'h7777, 1'b0, 16'h0000, lat);
        push_rd(16'h6000);
        run_op(3'd0, 16'h6000, 16'h0, 1'b0, 16'h7777, lat);

        run_op(3'd7, 16'h1234, 16'h5678, 1'b0, 16'h0000, lat);
        check("nop_latency", 36'(lat), 36'd1);

        preload(16'hFFFE, 16'h0F0F);
        push_rd(16'hFFFE);
        run_op(3'd0, 16'hFFFF, 16'h0, 1'b0, 16'h0F0F, lat);

        // start held high through a busy op with a different op code
        wait_n = 3;
        push_rd(16'h2002);
        exp_q.push_back({1'b0, 16'hCAFE});
        @(posedge clk); #1;
        start = 1'b1; op = 3'd0; addr = 16'h2002;
        @(posedge clk); #1;
        op = 3'd1; addr = 16'h1111; wdata = 16'h9999;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy_latency", 36'(lat), 36'd5);
        check("done_stall_start1", 36'(stall), 36'd1);
        start = 1'b0;
        #1;
        check("done_stall_start0", 36'(stall), 36'd0);
        wait_n = 0;

        // reset while LDI is waiting in its second access
        wait_n = 1;
        push_rd(16'h4000);
        @(posedge clk); #1;
        start = 1'b1; op = 3'd4; addr = 16'h4000;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("acc2_before_reset", {19'h0, mem_read, mem_address}, {19'h0, 1'b1, 16'h5002});
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("after_reset_idle", {32'h0, mem_read, mem_write, stall, done}, 36'h0);
        check("after_reset_rdata", 36'(rdata), 36'h0);
        force_resp = 1'b1;
        @(posedge clk); #1;
        force_resp = 1'b0;
        check("late_resp_ignored", {32'h0, mem_read, mem_write, stall, done}, 36'h0);
        wait_n = 0;

`ifdef MEMSEQ_WATCHDOG_EN
        resp_en = 1'b0;
        run_op(3'd0, 16'h3000, 16'h0, 1'b1, 16'h0000, lat);
        check("wd_latency", 36'(lat), 36'd5);
        check("wd_strobe_drop", 36'(mem_read), 36'd0);
        @(posedge clk); #1;
        check("wd_idle", {34'h0, stall, done}, 36'h0);
        resp_en = 1'b1;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("exp_queue_drained", 36'(exp_q.size()), 36'd0);
        check("acc_queue_drained", 36'(acc_q.size()), 36'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
